bcd_share_arbiter: RTL and testbench
====================================

Name: bcd_share_arbiter

Overview:
- Sequential double-dabble binary-to-BCD engine shared by two requesters, e.g. the sqrt operand and the sqrt root, both feeding the display path.
- Round-robin arbitration picks one request and converts it with one shift per clock.
- The result is presented on a valid/ready output port, tagged with the source requester.
- Replaces two combinational converters with one small multi-cycle unit.

Parameters:
- W, 8, binary input width. Legal range 1 to 16.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^W - 1; any other combination is unsupported.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  requester 0 has data.
- req0_data  input  W  requester 0 binary value.
- req0_ready  output  1  requester 0 is accepted this cycle.
- req1_valid  input  1  requester 1 has data.
- req1_data  input  W  requester 1 binary value.
- req1_ready  output  1  requester 1 is accepted this cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_src  output  1  source of the result (0 = req0, 1 = req1).
- out_bcd  output  4*DIGITS  packed BCD result, most significant digit at the top.
- busy  output  1  high in CONV or HOLD.

Behaviour:
- Reset is asynchronous and active-low. While rst_n = 0:
  - state = IDLE.
  - out_valid = 0, out_bcd = 0, out_src = 0, busy = 0.
  - req0_ready = req1_ready = 0.
  - last_grant = 1, so req0 wins the first tie.
  - Any in-flight conversion is discarded with no partial output.
- States are IDLE, CONV, HOLD.
- IDLE, grant logic:
  - If only one valid is high, that requester is granted.
  - If both are high, the requester not equal to last_grant is granted.
  - reqN_ready = (state == IDLE) && granted N. This is combinational from the valid inputs, and at most one ready is high.
  - The ready of a non-granted requester is 0 in every state.
- IDLE, capture on reqN_valid && reqN_ready:
  - shift register (4*DIGITS + W bits) <= {0, reqN_data}.
  - src <= N, last_grant <= N, bit counter <= 0.
  - state <= CONV.
- CONV, each cycle:
  - Every BCD digit field >= 5 gets +3, applied to all digits in the same cycle.
  - Then the whole register shifts left by 1.
  - counter <= counter + 1.
  - After the W-th shift, state <= HOLD: load out_bcd from the upper 4*DIGITS bits, out_src <= src, out_valid <= 1.
- Latency: capture edge plus exactly W further edges, then out_valid is high.
- HOLD:
  - out_valid, out_bcd and out_src stay stable until out_valid && out_ready.
  - On that edge: out_valid <= 0, state <= IDLE.
  - out_bcd and out_src keep their last values after the handshake; only out_valid qualifies them.
  - No request is accepted in CONV or HOLD. Requesters must hold valid and data until ready (standard valid/ready).
- Throughput: one conversion per W+2 cycles at best (capture, W shifts, and at least one HOLD cycle). The next capture comes the cycle after the output handshake.
- Back-to-back: a requester that stays valid after being served loses to the other requester if that one is valid. Otherwise it is re-granted.
- Changing data or withdrawing valid while not ready is a protocol violation; behaviour is unspecified, but the block must not lock up.
- Boundary values:
  - Input 0 gives all-zero BCD.
  - Input 2^W - 1 gives its full decimal value with no digit over 9.
  - The counter must not wrap before W.

Test Plan:
- req0 alone, data = 255, out_ready held 1: req0_ready pulses for 1 cycle; out_valid rises exactly 8 cycles after capture; out_bcd = 12'h255, out_src = 0; busy falls the cycle after the handshake.
- req0 = 0 and req1 = 99 both valid at once after reset: req0 is granted first and returns 12'h000 with src 0; req1_ready stays low until IDLE, then req1 returns 12'h099 with src 1.
- Both valid continuously with data 37 and 200: out_src alternates 0,1,0,1 over 6 results; BCD values are 12'h037 and 12'h200.
- Backpressure, req1 = 128, out_ready low for 5 cycles in HOLD: out_valid stays 1, out_bcd stays 12'h128; neither ready asserts while req0 is valid; the result completes when out_ready = 1.
- rst_n pulsed low for 1 cycle at the 4th CONV cycle: all outputs read 0 immediately (asynchronous); a following req1 = 42 alone converts to 12'h042, src 1.
- Sweep 0..255 on req0 with random out_ready stalls, compared against a reference model: every result is correct and every digit is <= 9.

Source files
------------

// File: rtl/bcd_share_arbiter.sv
// Shared sequential double-dabble binary-to-BCD converter with round-robin
// arbitration between two valid/ready requesters and a valid/ready result port.
module bcd_share_arbiter #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0_valid,
    input  logic [W-1:0]        req0_data,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [W-1:0]        req1_data,
    output logic                req1_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_src,
    output logic [4*DIGITS-1:0] out_bcd,
    output logic                busy
);

    localparam int BW = 4 * DIGITS;
    localparam int SW = BW + W;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

    state_t        state, state_next;
    logic [SW-1:0] shift_reg, shift_adj, shift_next;
    logic [CW-1:0] count;
    logic          last_grant, src;
    logic          grant0, grant1, last_shift;

    // On a tie the requester that was not served last wins.
    assign grant0     = req0_valid && (!req1_valid || last_grant);
    assign grant1     = req1_valid && (!req0_valid || !last_grant);
    assign last_shift = (count == CW'(W - 1));
    assign shift_next = shift_adj << 1;

    always_comb begin
        shift_adj = shift_reg;
        for (int d = 0; d < DIGITS; d++) begin
            if (shift_reg[W+4*d +: 4] >= 4'd5)
                shift_adj[W+4*d +: 4] = shift_reg[W+4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1)
                    state_next = CONV;
            end
            CONV: begin
                busy = 1'b1;
                if (last_shift)
                    state_next = HOLD;
            end
            HOLD: begin
                busy = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // out_bcd and out_src are left untouched after the handshake; out_valid qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            count      <= '0;
            last_grant <= 1'b1;
            src        <= 1'b0;
            out_valid  <= 1'b0;
            out_bcd    <= '0;
            out_src    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        shift_reg  <= {{BW{1'b0}}, req0_data};
                        src        <= 1'b0;
                        last_grant <= 1'b0;
                        count      <= '0;
                    end else if (req1_ready) begin
                        shift_reg  <= {{BW{1'b0}}, req1_data};
                        src        <= 1'b1;
                        last_grant <= 1'b1;
                        count      <= '0;
                    end
                end
                CONV: begin
                    shift_reg <= shift_next;
                    count     <= count + CW'(1);
                    if (last_shift) begin
                        out_bcd   <= shift_next[SW-1 -: BW];
                        out_src   <= src;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_share_arbiter.sv
// Directed and sweep testbench for bcd_share_arbiter (W=8, DIGITS=3).
module tb_bcd_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_data, req1_data;
    logic        out_valid, out_ready, out_src, busy;
    logic [11:0] out_bcd;

    int checks = 0;
    int errors = 0;

    bcd_share_arbiter #(.W(8), .DIGITS(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .out_bcd    (out_bcd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0,
                                 input logic v1, input logic [7:0] d1, input logic ordy);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        out_ready  = ordy;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b0);
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_bcd", out_bcd, 0);
        checkOutput("rst_out_src", out_src, 0);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid)
            checkOutput("timeout_out_valid", 0, 1);
    endtask

    function automatic logic [11:0] toBcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int n;
        logic [11:0] exp;
        logic        digits_ok;

        applyReset();

        // Single requester, maximum input value
        applyStimulus(1'b1, 8'd255, 1'b0, 8'd0, 1'b1);
        #1;
        checkOutput("t1_req0_ready", req0_ready, 1);
        checkOutput("t1_req1_ready", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checkOutput("t1_ready_pulse", req0_ready, 0);
        checkOutput("t1_busy", busy, 1);
        waitValid(lat);
        checkOutput("t1_latency", lat, 8);
        checkOutput("t1_bcd", out_bcd, 12'h255);
        checkOutput("t1_src", out_src, 0);
        @(negedge clk);
        checkOutput("t1_valid_drop", out_valid, 0);
        checkOutput("t1_busy_drop", busy, 0);

        // Simultaneous requests after reset: req0 wins first tie
        applyReset();
        applyStimulus(1'b1, 8'd0, 1'b1, 8'd99, 1'b1);
        #1;
        checkOutput("t2_req0_ready", req0_ready, 1);
        checkOutput("t2_req1_ready", req1_ready, 0);
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checkOutput("t2_req1_blocked", req1_ready, 0);
        waitValid(lat);
        checkOutput("t2_bcd0", out_bcd, 12'h000);
        checkOutput("t2_src0", out_src, 0);
        @(negedge clk);
        #1;
        checkOutput("t2_req1_granted", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        waitValid(lat);
        checkOutput("t2_bcd1", out_bcd, 12'h099);
        checkOutput("t2_src1", out_src, 1);
        @(negedge clk);

        // Both requesters held valid: results alternate starting with req0
        applyStimulus(1'b1, 8'd37, 1'b1, 8'd200, 1'b1);
        for (int k = 0; k < 6; k++) begin
            waitValid(lat);
            checkOutput($sformatf("t3_src%0d", k), out_src, k % 2);
            checkOutput($sformatf("t3_bcd%0d", k), out_bcd, (k % 2) ? 12'h200 : 12'h037);
            @(negedge clk);
        end
        applyStimulus(1'b0, 8'd0, 1'b0, 8'd0, 1'b1);
        @(negedge clk);

        // Backpressure in HOLD while req0 waits
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd128, 1'b0);
        #1;
        checkOutput("t4_req1_ready", req1_ready, 1);
        @(negedge clk);
        applyStimulus(1'b1, 8'd5, 1'b0, 8'd0, 1'b0);
        waitValid(lat);
        checkOutput("t4_latency", lat, 8);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("t4_hold_valid", out_valid, 1);
            checkOutput("t4_hold_bcd", out_bcd, 12'h128);
            checkOutput("t4_hold_src", out_src, 1);
            checkOutput("t4_hold_r0", req0_ready, 0);
            checkOutput("t4_hold_r1", req1_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("t4_released", out_valid, 0);
        checkOutput("t4_req0_next", req0_ready, 1);
        @(negedge clk);
        req0_valid = 1'b0;
        waitValid(lat);
        checkOutput("t4_bcd_req0", out_bcd, 12'h005);
        checkOutput("t4_src_req0", out_src, 0);
        @(negedge clk);
        #1;
        checkOutput("t4_bcd_kept", out_bcd, 12'h005);
        checkOutput("t4_valid_low", out_valid, 0);

        // Asynchronous reset during the fourth conversion cycle
        applyStimulus(1'b1, 8'd200, 1'b0, 8'd0, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_valid", out_valid, 0);
        checkOutput("t5_bcd", out_bcd, 0);
        checkOutput("t5_src", out_src, 0);
        checkOutput("t5_busy", busy, 0);
        checkOutput("t5_r0", req0_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 8'd0, 1'b1, 8'd42, 1'b1);
        #1;
        checkOutput("t5_req1_ready", req1_ready, 1);
        @(negedge clk);
        req1_valid = 1'b0;
        waitValid(lat);
        checkOutput("t5_bcd42", out_bcd, 12'h042);
        checkOutput("t5_src42", out_src, 1);
        @(negedge clk);

        // Full sweep on req0 with random output stalls
        for (int v = 0; v < 256; v++) begin
            applyStimulus(1'b1, 8'(v), 1'b0, 8'd0, 1'($urandom_range(0, 1)));
            n = 0;
            #1;
            while (!req0_ready && n < 60) begin
                @(negedge clk);
                #1;
                n++;
            end
            if (!req0_ready)
                checkOutput("sw_ready_timeout", 0, 1);
            @(negedge clk);
            req0_valid = 1'b0;
            waitValid(lat);
            exp = toBcd(v);
            digits_ok = (out_bcd[3:0] <= 4'd9) && (out_bcd[7:4] <= 4'd9) && (out_bcd[11:8] <= 4'd9);
            checkOutput($sformatf("sw_bcd_%0d", v), out_bcd, exp);
            checkOutput($sformatf("sw_src_%0d", v), out_src, 0);
            checkOutput($sformatf("sw_digits_%0d", v), digits_ok, 1);
            n = 0;
            while (out_valid && n < 60) begin
                out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                n++;
                if (out_valid)
                    checkOutput($sformatf("sw_stable_%0d", v), out_bcd, exp);
            end
            if (out_valid)
                checkOutput("sw_handshake_timeout", 0, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
